// File: rtl/ultrasonic_sample_fifo_if.sv
// Sample-capture FIFO bus: ADC/PIO inputs toward the buffer, head word and status back.
// The master modport drives stimulus; the slave modport is the buffer side.
interface ultrasonic_sample_fifo_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;
    logic              arm;
    logic [ADDR_W:0]   capture_len;
    logic              pop_req;
    logic [DATA_W-1:0] fifo_data;
    logic              empty;
    logic              full;
    logic              capturing;
    logic              done;
    logic              overflow;
    logic              underrun;
    logic [ADDR_W:0]   count;

    modport master (
        output adc_data, adc_valid, arm, capture_len, pop_req,
        input  fifo_data, empty, full, capturing, done, overflow, underrun, count
    );

    modport slave (
        input  adc_data, adc_valid, arm, capture_len, pop_req,
        output fifo_data, empty, full, capturing, done, overflow, underrun, count
    );
endinterface

// File: rtl/ultrasonic_sample_fifo.sv
// Armed-window ADC capture FIFO feeding a PIO; head word on fifo_data, 1-cycle pop latency.
// No backpressure: samples arriving while full are dropped (overflow), pops while empty set underrun.
module ultrasonic_sample_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    ultrasonic_sample_fifo_if.slave  bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAP  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              arm_q, arm_p, pop_q, pop_p;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [ADDR_W:0]   count_q, count_d, smp_q, smp_d, len_q, len_d;
    logic              ovf_q, ovf_d, und_q, und_d;
    logic              head_vld_q, head_vld_d, byp_q, byp_d;
    logic [DATA_W-1:0] byp_dat_q, rd_dat_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic arm_evt, pop_evt, empty_w, full_w, in_cap, smp_vld, wr_en, pop_ok;

    always_comb begin
        arm_evt = arm_q & ~arm_p;
        pop_evt = pop_q ^ pop_p;
        empty_w = (count_q == '0);
        full_w  = (count_q == DEPTH_C);
        in_cap  = (state_q == ST_CAP);
        smp_vld = in_cap & bus.adc_valid & ~arm_evt;
        wr_en   = smp_vld & ~full_w;
        pop_ok  = pop_evt & ~empty_w;
        rd_addr = pop_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        smp_d    = smp_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        und_d    = und_q;

        if (arm_evt) begin
            state_d  = ST_CAP;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            smp_d    = '0;
            ovf_d    = 1'b0;
            und_d    = 1'b0;
            len_d    = (bus.capture_len == '0 || bus.capture_len > DEPTH_C) ? DEPTH_C : bus.capture_len;
        end else begin
            // Window is counted in sample time: dropped samples still consume it.
            if (in_cap && smp_q == len_q) state_d = ST_DONE;
            if (smp_vld)                  smp_d = smp_q + CNT_ONE;
            if (smp_vld && full_w)        ovf_d = 1'b1;
            if (wr_en)                    wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_ok)                   rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (pop_evt && empty_w)       und_d = 1'b1;
            unique case ({wr_en, pop_ok})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Head is shown only once the word has been stored for a full cycle.
        head_vld_d = ~empty_w & (count_d != '0);
        // Pop of the only word while its successor is written: RAM read would return stale data.
        byp_d      = wr_en & (wr_ptr_q == rd_addr);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.adc_data;
        rd_dat_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            arm_p      <= 1'b0;
            pop_q      <= 1'b0;
            pop_p      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            smp_q      <= '0;
            len_q      <= DEPTH_C;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
            head_vld_q <= 1'b0;
            byp_q      <= 1'b0;
            byp_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= bus.arm;
            arm_p      <= arm_q;
            pop_q      <= bus.pop_req;
            pop_p      <= pop_q;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            smp_q      <= smp_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            head_vld_q <= head_vld_d;
            byp_q      <= byp_d;
            byp_dat_q  <= bus.adc_data;
        end
    end

    assign bus.fifo_data = head_vld_q ? (byp_q ? byp_dat_q : rd_dat_q) : '0;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.capturing = in_cap;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.overflow  = ovf_q;
    assign bus.underrun  = und_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_ultrasonic_sample_fifo.sv
// Bench for ultrasonic_sample_fifo: randomized stimulus against a queue-based reference model.
module tb_ultrasonic_sample_fifo;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ultrasonic_sample_fifo_if u ();
    ultrasonic_sample_fifo dut (.clk(clk), .reset_n(reset_n), .bus(u.slave));

    int total = 0;
    int bad = 0;

    // Reference model: the FIFO is a queue, state is 0 idle / 1 capture / 2 done.
    logic [15:0] q [$];
    int          m_state, m_smp, m_len;
    bit          m_ovf, m_und;
    logic        m_arm_q, m_arm_p, m_pop_q, m_pop_p;
    logic [15:0] m_data;

    wire [32:0] dut_vec = {u.fifo_data, u.empty, u.full, u.capturing, u.done,
                           u.overflow, u.underrun, u.count};
    localparam logic [32:0] RST_VEC = {16'h0, 1'b1, 5'b0, 11'd0};

    function automatic logic [32:0] exp_vec();
        int n = q.size();
        return {m_data, n == 0, n == 1024, m_state == 1, m_state == 2, m_ovf, m_und, 11'(n)};
    endfunction

    task automatic model_reset();
        q.delete();
        m_state = 0; m_smp = 0; m_len = 1024; m_ovf = 0; m_und = 0;
        m_arm_q = 0; m_arm_p = 0; m_pop_q = 0; m_pop_p = 0; m_data = 16'h0;
    endtask

    task automatic model_update();
        logic aev, pev;
        int   prev;
        bit   dn;
        aev  = m_arm_q & ~m_arm_p;
        pev  = m_pop_q ^ m_pop_p;
        prev = q.size();
        if (aev) begin
            q.delete();
            m_smp = 0; m_ovf = 0; m_und = 0; m_state = 1;
            m_len = (u.capture_len == 0 || u.capture_len > 1024) ? 1024 : int'(u.capture_len);
        end else begin
            dn = (m_state == 1 && m_smp == m_len);
            if (pev) begin
                if (prev > 0) void'(q.pop_front());
                else m_und = 1;
            end
            if (m_state == 1 && u.adc_valid) begin
                m_smp++;
                if (prev < 1024) q.push_back(u.adc_data);
                else m_ovf = 1;
            end
            if (dn) m_state = 2;
        end
        m_data  = (q.size() > 0 && prev > 0) ? q[0] : 16'h0;
        m_arm_p = m_arm_q; m_arm_q = u.arm;
        m_pop_p = m_pop_q; m_pop_q = u.pop_req;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic tog);
        @(negedge clk);
        u.adc_valid = v;
        u.adc_data  = d;
        if (tog) u.pop_req = ~u.pop_req;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic arm_rise(input logic [10:0] len);
        u.capture_len = len;
        u.arm = 1'b0;
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        u.arm = 1'b1;
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        u.adc_valid = 0; u.adc_data = 0; u.arm = 0; u.pop_req = 0; u.capture_len = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec !== RST_VEC) begin
            bad++; $display("FAIL reset_values: got %h want %h", dut_vec, RST_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_capture_drain();
        logic [15:0] seq [6] = '{16'h0102, 16'h0103, 16'h0104, 16'h0, 16'h0, 16'h0};
        arm_rise(4);
        total++;
        if (u.capturing !== 1'b1) begin bad++; $display("FAIL cd_capturing: got %b want 1", u.capturing); end
        for (int i = 0; i < 4; i++) begin
            step(1, 16'h0101 + 16'(i), 0);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL cd_fill: got %h want %h", dut_vec, exp_vec()); end
            step(0, 16'h0, 0);
        end
        repeat (3) step(0, 16'h0, 0);
        total++;
        if ({u.count, u.done, u.fifo_data} !== {11'd4, 1'b1, 16'h0101}) begin
            bad++; $display("FAIL cd_full_window: got cnt=%0d done=%b head=%h want 4 1 0101", u.count, u.done, u.fifo_data);
        end
        for (int k = 0; k < 6; k++) begin
            step(0, 16'h0, 1);
            step(0, 16'h0, 0);
            step(0, 16'h0, 0);
            total++;
            if (u.fifo_data !== seq[k]) begin bad++; $display("FAIL cd_pop%0d: got %h want %h", k, u.fifo_data, seq[k]); end
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL cd_drain: got %h want %h", dut_vec, exp_vec()); end
            if (k == 4) begin
                total++;
                if (u.underrun !== 1'b1) begin bad++; $display("FAIL cd_underrun: got %b want 1", u.underrun); end
            end
        end
    endtask

    task automatic test_overflow_wrap();
        arm_rise(0);
        for (int i = 0; i < 1030; i++) begin
            step(1, 16'(i), 0);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ow_fill%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        total++;
        if ({u.full, u.count, u.overflow, u.done} !== {1'b1, 11'd1024, 1'b1, 1'b1}) begin
            bad++; $display("FAIL ow_full: got f=%b c=%0d o=%b d=%b want 1 1024 1 1", u.full, u.count, u.overflow, u.done);
        end
        for (int i = 0; i < 1024; i++) begin
            total++;
            if (u.fifo_data !== 16'(i)) begin bad++; $display("FAIL ow_head%0d: got %h want %h", i, u.fifo_data, 16'(i)); end
            step(0, 16'h0, 1);
            step(0, 16'h0, 0);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ow_drain: got %h want %h", dut_vec, exp_vec()); end
        end
        arm_rise(8);
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), (i % 3 == 2));
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL ow_rearm: got %h want %h", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_concurrent();
        arm_rise(16);
        for (int i = 0; i < 3; i++) step(1, 16'hA001 + 16'(i), 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 1);
        step(1, 16'h5555, 0);
        step(0, 16'h0, 0);
        total++;
        if ({u.count, u.fifo_data} !== {11'd3, 16'hA002}) begin
            bad++; $display("FAIL cc_count_head: got %0d %h want 3 a002", u.count, u.fifo_data);
        end
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL cc_model: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_rearm_mid();
        arm_rise(32);
        step(0, 16'h0, 1);
        step(0, 16'h0, 0);
        for (int i = 0; i < 7; i++) step(1, 16'($urandom), 0);
        step(0, 16'h0, 0);
        total++;
        if ({u.count, u.underrun} !== {11'd7, 1'b1}) begin
            bad++; $display("FAIL rm_before: got %0d %b want 7 1", u.count, u.underrun);
        end
        u.arm = 1'b0;
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        u.arm = 1'b1;
        step(0, 16'h0, 0);
        step(1, 16'hDEAD, 0);
        total++;
        if ({u.count, u.fifo_data, u.overflow, u.underrun, u.capturing} !== {11'd0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rm_flush: got %h want cnt0 data0 flags0 cap1", dut_vec);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 16'h0, 0);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rm_after: got %h want %h", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_clamp_arm_level();
        int since = 9;
        logic tog;
        arm_rise(11'd2047);
        for (int i = 0; i < 1400; i++) begin
            tog = (since >= 2) && ($urandom_range(0, 15) == 0);
            since = tog ? 0 : since + 1;
            step(1'($urandom_range(0, 7) != 0), 16'($urandom), tog);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL cl_run: got %h want %h", dut_vec, exp_vec()); end
        end
        total++;
        if ({u.done, u.capturing} !== 2'b10) begin bad++; $display("FAIL cl_done_held: got %b%b want 10", u.done, u.capturing); end
        u.arm = 1'b0;
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        u.arm = 1'b1;
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        total++;
        if ({u.done, u.capturing, u.count} !== {1'b0, 1'b1, 11'd0}) begin
            bad++; $display("FAIL cl_restart: got d=%b c=%b n=%0d want 0 1 0", u.done, u.capturing, u.count);
        end
    endtask

    task automatic test_random();
        int since = 9;
        logic tog;
        int lens [6] = '{0, 1, 5, 17, 1024, 1500};
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 150) == 0) begin
                u.arm = ~u.arm;
                u.capture_len = 11'(lens[$urandom_range(0, 5)]);
            end
            tog = (since >= 2) && ($urandom_range(0, 2) == 0);
            since = tog ? 0 : since + 1;
            step(1'($urandom_range(0, 1)), 16'($urandom), tog);
            total++;
            if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rnd%0d: got %h want %h", i, dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        arm_rise(20);
        for (int i = 0; i < 5; i++) step(1, 16'h7000 + 16'(i), 0);
        step(0, 16'h0, 0);
        total++;
        if (u.count !== 11'd5) begin bad++; $display("FAIL rst_mid_pre: got %0d want 5", u.count); end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (dut_vec !== RST_VEC) begin bad++; $display("FAIL rst_mid: got %h want %h", dut_vec, RST_VEC); end
        u.arm = 0; u.pop_req = 0; u.adc_valid = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 16'h0, 0);
        total++;
        if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rst_mid_after: got %h want %h", dut_vec, exp_vec()); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture_drain();
        test_overflow_wrap();
        test_concurrent();
        test_rearm_mid();
        test_clamp_arm_level();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ultrasonic_sample_fifo.md
# ultrasonic_sample_fifo

Capture buffer that sits directly upstream of the NIOS FIFO data PIO. It records a software-armed window of 16-bit ultrasonic ADC samples into on-chip RAM. The head word is presented continuously on `fifo_data`, which is wired to the PIO's 16-bit input port. Software pops one word per toggle of a PIO output bit and reads status bits through a second PIO.

## Interface
- `DATA_W`, 16, sample width (fixed by downstream PIO width)
- `ADDR_W`, 10, RAM address width; DEPTH = 2^ADDR_W = 1024 words

- `clk`  in  1  system clock; ADC, NIOS and PIOs all run in this domain
- `reset_n`  in  1  asynchronous, active-low reset
- `adc_data`  in  DATA_W  ADC sample
- `adc_valid`  in  1  one-cycle qualifier for `adc_data`
- `arm`  in  1  level from PIO; rising edge flushes and starts capture
- `capture_len`  in  ADDR_W+1  samples per window; 0 means DEPTH; values above DEPTH clamp to DEPTH
- `pop_req`  in  1  level from PIO; every transition (either direction) is one pop
- `fifo_data`  out  DATA_W  head word, or 0 when empty; feeds PIO in_port
- `empty`, `full`  out  1  FIFO state
- `capturing`, `done`  out  1  state flags
- `overflow`  out  1  sticky: a sample arrived while full
- `underrun`  out  1  sticky: pop requested while empty
- `count`  out  ADDR_W+1  words stored, 0..DEPTH

## Operation
- **Edge detection:**
  - `arm_q`/`arm_p` and `pop_q`/`pop_p` are two-register chains.
  - arm_evt = arm_q & ~arm_p.
  - pop_evt = pop_q ^ pop_p.
- **States:** IDLE, CAPTURE, DONE.
  - IDLE → CAPTURE on arm_evt.
  - CAPTURE → DONE when the sample counter equals the effective length.
  - DONE → CAPTURE on arm_evt.
  - arm_evt in CAPTURE restarts the window.
- **On arm_evt (any state):**
  - wr_ptr, rd_ptr, count, sample counter, overflow and underrun clear.
  - fifo_data goes to 0.
  - The effective length is latched from `capture_len`.
  - An `adc_valid` in the same cycle is discarded.
- **In CAPTURE:**
  - Every `adc_valid` increments the sample counter, whether or not the sample is stored, so the window is fixed in sample time.
  - If not full, `adc_data` is written at wr_ptr, wr_ptr wraps modulo DEPTH, and count increments.
  - If full, the sample is dropped and overflow sets.
- **Outside CAPTURE:** `adc_valid` is ignored.
- **Pop (any state):**
  - pop_evt with count>0: rd_ptr wraps modulo DEPTH and count decrements.
  - pop_evt with count==0: no pointer change; underrun sets.
- **Simultaneous write and pop with count>0:** both pointers advance and count is unchanged.
- **Simultaneous write and pop with count==0:** the write is stored and the pop sets underrun.
- **Flags:**
  - empty = (count==0); full = (count==DEPTH).
  - capturing = (state==CAPTURE); done = (state==DONE).
  - All are registered, or decoded from registered state.
- **RAM:** simple dual-port, registered read. Read address = rd_ptr + (pop_evt & ~empty).

## Timing
- **Reset values:** state IDLE, all pointers and counters 0, fifo_data 0, empty 1, full 0, capturing 0, done 0, overflow 0, underrun 0, count 0.
- **arm:**
  - rises before edge N → arm_q at N → flush takes effect at edge N+1.
  - capturing=1 after N+1.
  - First storable sample is one with `adc_valid` in the cycle after N+1.
- **pop_req:**
  - toggles before edge N → pop_evt during cycle N..N+1 → rd_ptr, count and fifo_data update at edge N+1.
  - Toggles closer than 1 cycle apart are not supported; software spacing is far larger.
- **Write into empty FIFO:**
  - write and count=1 at edge W.
  - fifo_data shows the sample from edge W+1.
  - Software must wait for empty=0 before reading.
- **Last pop:** when the last word is popped, fifo_data goes to 0 at the same edge count reaches 0.
- **Done:** asserts at the edge after the edge that accepts the final sample.
- **Reset mid-capture or mid-read:** returns immediately to reset values; RAM contents are don't-care.

## Test plan
- **Reset:** assert reset_n=0 mid-capture with count=5 → all outputs at reset values, empty=1, fifo_data=0.
- **Capture and drain:**
  - capture_len=4; arm rise; feed 0x0101..0x0104 → count=4 and done=1.
  - Six toggles of pop_req → fifo_data sequence 0x0101, 0x0102, 0x0103, 0x0104, then 0.
  - underrun=1 after the fifth toggle.
- **Overflow and wrap:**
  - capture_len=0 (full depth); 1030 samples valued i with no pops → full=1, count=1024, overflow=1, done=1 after sample 1024.
  - Pop 1024 → values 0..1023 in order.
  - Re-arm and capture 8 → pointers wrap correctly.
- **Concurrent write and pop:** during CAPTURE with count=3, assert adc_valid and a pop_req toggle in the same cycle → count stays 3, head advances by one.
- **Re-arm mid-capture:**
  - Arm rises while count=7 → count=0, overflow/underrun cleared, fifo_data=0.
  - adc_valid in the flush cycle is not stored.
- **Length clamp and arm level:**
  - capture_len=2047 → window ends at 1024 samples.
  - Holding arm high across done does not restart; only a new rising edge restarts.
